// File: rtl/mhp_pkg.sv
// Shared constants for the ethernet frame responder: FSM state codes,
// reply mode codes and the fixed reply template.
package mhp_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_CAP  = 3'd1;
  localparam logic [2:0] ST_RD_GAP  = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_TX_ADDR = 3'd4;
  localparam logic [2:0] ST_TX_DATA = 3'd5;
  localparam logic [2:0] ST_TX_PUSH = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  // Reply modes; code 3 is reserved and behaves as ECHO
  localparam logic [1:0] MODE_ECHO     = 2'd0;
  localparam logic [1:0] MODE_ZERO     = 2'd1;
  localparam logic [1:0] MODE_TEMPLATE = 2'd2;

  localparam int TPL_LEN = 9;

  // Template header bytes: ff ff 00 00 00 00 83 09 05
  function automatic logic [7:0] tpl_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0, 4'd1: b = 8'hff;
      4'd6:       b = 8'h83;
      4'd7:       b = 8'h09;
      4'd8:       b = 8'h05;
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_frame_buf.sv
// Single-port synchronous frame buffer, DEPTH x DW, one-cycle read latency.
// Contents are deliberately not reset.
module eth_frame_buf
  import mhp_pkg::*;
#(
  parameter int DW     = 8,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DW-1:0]     i_wdata,
  output logic [DW-1:0]     o_rdata
);

  logic [DW-1:0] r_mem [2**ADDR_W];

  // Write on enable; always register the addressed word for the next cycle
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/eth_frame_responder.sv
// Ethernet frame responder: captures one RX payload into a local buffer,
// detects end of frame by an idle gap, waits a number of seconds ticks and
// replies on the TX FIFO in ECHO, ZERO or TEMPLATE mode, padded to MIN_LEN.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | waiting for RX FIFO non-empty
//   RD_CAP     | popped word is on i_rdata; store it (or drop on overflow)
//   RD_GAP     | between pops; count idle cycles to find end of frame
//   WAIT       | reply parameters latched; wait for the seconds delay
//   TX_ADDR    | buffer address presented for reply word i
//   TX_DATA    | buffer data returned; choose the reply word
//   TX_PUSH    | push word when TX FIFO ready, advance i
//   DONE       | pulse o_done, back to IDLE
module eth_frame_responder
  import mhp_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            ADDR_W   = 10,
  parameter int            IDLE_GAP = 62,
  parameter int            MIN_LEN  = 50,
  parameter logic [DW-1:0] PAD_WORD = '0,
  parameter int            TICK_DIV = 50000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_mode,
  input  logic [7:0]        i_delay,
  input  logic [DW-1:0]     i_rdata,
  input  logic              i_rready,
  output logic              o_rreq,
  output logic [DW-1:0]     o_wdata,
  input  logic              i_wready,
  output logic              o_wvalid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output logic [ADDR_W:0]   o_rx_len,
  output logic [31:0]       o_time
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LW    = ADDR_W + 1;
  localparam int TW    = ADDR_W + 2;
  localparam int GAP_W = $clog2(IDLE_GAP);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [2:0]        r_state;
  logic [LW-1:0]     r_wr_ptr;
  logic [GAP_W-1:0]  r_gap;
  logic [1:0]        r_mode;
  logic [7:0]        r_delay;
  logic [7:0]        r_tcnt;
  logic [TW-1:0]     r_tx_len;
  logic [TW-1:0]     r_idx;
  logic [DW-1:0]     r_word;
  logic [DIV_W-1:0]  r_div;

  logic              w_tick;
  logic              w_buf_we;
  logic [ADDR_W-1:0] w_buf_addr;
  logic [DW-1:0]     w_buf_rdata;
  logic [1:0]        w_mode_in;
  logic [TW-1:0]     w_body;
  logic [TW-1:0]     w_tx_len;
  logic [TW-1:0]     w_tpl_off;
  logic [TW-1:0]     w_idx_next;
  logic [DW-1:0]     w_sel_word;

  assign w_tick     = (r_div == DIV_W'(TICK_DIV - 1));
  assign o_busy     = (r_state != ST_IDLE);
  assign w_tpl_off  = r_idx - TW'(TPL_LEN);
  assign w_idx_next = r_idx + TW'(1);

  // Reply length from the captured length and the incoming mode (reserved -> ECHO)
  always_comb begin
    w_mode_in = MODE_ECHO;
    if (i_mode == MODE_ZERO || i_mode == MODE_TEMPLATE) begin
      w_mode_in = i_mode;
    end
    w_body = {1'b0, o_rx_len};
    if (w_mode_in == MODE_TEMPLATE) begin
      w_body = w_body + TW'(TPL_LEN);
    end
    w_tx_len = (w_body < TW'(MIN_LEN)) ? TW'(MIN_LEN) : w_body;
  end

  // Buffer port: write pointer while capturing, reply index (template-offset) otherwise
  always_comb begin
    w_buf_we   = (r_state == ST_RD_CAP) && (r_wr_ptr < LW'(DEPTH));
    w_buf_addr = r_idx[ADDR_W-1:0];
    if (r_state == ST_RD_CAP) begin
      w_buf_addr = r_wr_ptr[ADDR_W-1:0];
    end else if (r_mode == MODE_TEMPLATE) begin
      w_buf_addr = ADDR_W'(w_tpl_off);
    end
  end

  // Reply word for index r_idx; anything beyond the stored payload is padding
  always_comb begin
    w_sel_word = PAD_WORD;
    case (r_mode)
      MODE_ZERO: w_sel_word = PAD_WORD;
      MODE_TEMPLATE: begin
        if (r_idx < TW'(TPL_LEN)) begin
          w_sel_word = DW'(tpl_byte(r_idx[3:0]));
        end else if (w_tpl_off < {1'b0, o_rx_len}) begin
          w_sel_word = w_buf_rdata;
        end
      end
      default: begin
        if (r_idx < {1'b0, o_rx_len}) begin
          w_sel_word = w_buf_rdata;
        end
      end
    endcase
  end

  eth_frame_buf #(
    .DW     (DW),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (w_buf_we),
    .i_addr  (w_buf_addr),
    .i_wdata (i_rdata),
    .o_rdata (w_buf_rdata)
  );

  // Seconds tick divider and free-running seconds counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div  <= '0;
      o_time <= '0;
    end else if (w_tick) begin
      r_div  <= '0;
      o_time <= o_time + 32'd1;
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  // Capture / wait / reply sequencer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_gap    <= '0;
      r_mode   <= MODE_ECHO;
      r_delay  <= '0;
      r_tcnt   <= '0;
      r_tx_len <= '0;
      r_idx    <= '0;
      r_word   <= '0;
      o_rreq   <= 1'b0;
      o_wdata  <= '0;
      o_wvalid <= 1'b0;
      o_done   <= 1'b0;
      o_ovf    <= 1'b0;
      o_rx_len <= '0;
    end else begin
      o_rreq   <= 1'b0;
      o_wvalid <= 1'b0;
      o_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_rready) begin
            o_rreq   <= 1'b1;
            r_wr_ptr <= '0;
            o_rx_len <= '0;
            o_ovf    <= 1'b0;
            r_state  <= ST_RD_CAP;
          end
        end
        ST_RD_CAP: begin
          // Words past DEPTH are still popped so the FIFO drains, just not stored
          if (r_wr_ptr < LW'(DEPTH)) begin
            r_wr_ptr <= r_wr_ptr + LW'(1);
          end else begin
            o_ovf <= 1'b1;
          end
          if (o_rx_len != LW'(DEPTH)) begin
            o_rx_len <= o_rx_len + LW'(1);
          end
          r_gap   <= '0;
          r_state <= ST_RD_GAP;
        end
        ST_RD_GAP: begin
          if (i_rready) begin
            o_rreq  <= 1'b1;
            r_state <= ST_RD_CAP;
          end else if (r_gap == GAP_W'(IDLE_GAP - 1)) begin
            r_mode   <= w_mode_in;
            r_delay  <= i_delay;
            r_tx_len <= w_tx_len;
            r_tcnt   <= '0;
            r_state  <= ST_WAIT;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        ST_WAIT: begin
          if (r_tcnt >= r_delay) begin
            r_idx   <= '0;
            r_state <= ST_TX_ADDR;
          end else if (w_tick && r_tcnt != 8'hff) begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        ST_TX_ADDR: r_state <= ST_TX_DATA;
        ST_TX_DATA: begin
          r_word  <= w_sel_word;
          r_state <= ST_TX_PUSH;
        end
        ST_TX_PUSH: begin
          if (i_wready) begin
            o_wvalid <= 1'b1;
            o_wdata  <= r_word;
            r_idx    <= w_idx_next;
            r_state  <= (w_idx_next == r_tx_len) ? ST_DONE : ST_TX_ADDR;
          end
        end
        ST_DONE: begin
          o_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
